// File: rtl/sdf_ctrl_pkg.sv
// sdf_ctrl_pkg: shared control definitions for radix-2 SDF IFFT stages.
// Holds the stage state encoding, a constant log2 helper and the depth macro
// used by both the sequencer and the datapath Memory_Shifter instantiation.
`ifndef SDF_CTRL_PKG_SV
`define SDF_CTRL_PKG_SV

// Feedback buffer depth of stage number stage_no (1-based).
`define D(stage_no) (1 << ((stage_no) - 1))

package sdf_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    RUN   = 2'd2,
    DRAIN = 2'd3
  } sdf_state_t;

  // Ceiling log2 usable in constant expressions.
  function automatic int log2_ceil(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

`endif

// File: rtl/sdf_twiddle_addr_gen.sv
// sdf_twiddle_addr_gen: twiddle ROM address and multiply enable for one SDF
// stage. The address is (cnt mod D) * NFFT/(2D), held between advances so
// input gaps freeze it. The multiply is active only in the first half of
// each 2D block and never while the buffer is being drained.
module sdf_twiddle_addr_gen
  import sdf_ctrl_pkg::*;
#(
  parameter int NFFT     = 64,
  parameter int STAGE_NO = 1,
  parameter int AW       = $clog2(NFFT)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] cnt,
  input  logic          advance,
  input  logic          drain,
  output logic [AW-1:0] tw_addr,
  output logic          tw_en
);

  localparam int            DEPTH = `D(STAGE_NO);
  localparam int            SHIFT = log2_ceil(NFFT) - STAGE_NO;
  localparam logic [AW-1:0] MASK  = AW'(DEPTH - 1);

  logic [AW-1:0] addr_next;

  // NFFT/(2D) is a power of two, so the multiply reduces to a shift.
  assign addr_next = (cnt & MASK) << SHIFT;
  assign tw_en     = advance && !cnt[STAGE_NO-1] && !drain;

  // Address register, updated only when the stage advances.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tw_addr <= '0;
    end else if (advance) begin
      tw_addr <= addr_next;
    end
  end

endmodule

// File: rtl/sdf_stage_sequencer.sv
// sdf_stage_sequencer: control unit for one radix-2 SDF IFFT stage.
// Counts samples per frame, derives the butterfly/MUX selects and twiddle
// controls, qualifies the serial output and drains the feedback buffer after
// the final frame. Optional build macro SDF_SEQ_STATUS_EN adds the frame_cnt
// and sticky err status outputs.
module sdf_stage_sequencer
  import sdf_ctrl_pkg::*;
#(
  parameter int NFFT     = 64,
  parameter int STAGE_NO = 1,
  parameter int AW       = $clog2(NFFT)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start_conv,
  input  logic          stop_conv,
  input  logic          in_valid,
  output logic          sel1,
  output logic          sel2,
  output logic          tw_en,
  output logic [AW-1:0] tw_addr,
  output logic          flush,
  output logic          out_valid,
  output logic          out_last,
  output logic          busy,
  output logic          end_conv
`ifdef SDF_SEQ_STATUS_EN
  ,
  output logic [15:0]   frame_cnt,
  output logic          err
`endif
);

  localparam int            DEPTH     = `D(STAGE_NO);
  localparam logic [AW-1:0] CNT_LAST  = AW'(NFFT - 1);
  localparam logic [AW-1:0] DEPTH_END = AW'(DEPTH - 1);

  sdf_state_t    state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic          stop_req_q, stop_req_d;
  logic          advance;
  logic          cnt_at_last;
  logic          run_adv;
  logic          drain_done;
  logic          sel_p1;
  logic          vld_p1;
  logic          last_p1;
  logic          end_p1;

  assign busy        = (state_q != IDLE);
  assign flush       = (state_q == DRAIN);
  assign sel1        = busy && cnt_q[STAGE_NO-1];
  assign cnt_at_last = (cnt_q == CNT_LAST);
  assign run_adv     = (state_q == RUN) && advance;
  assign drain_done  = (state_q == DRAIN) && (cnt_q == DEPTH_END);

  // A start with in_valid in IDLE already carries sample 0; DRAIN advances
  // on its own to push zeros through the feedback buffer.
  always_comb begin
    advance = 1'b0;
    case (state_q)
      IDLE:      advance = start_conv && in_valid;
      FILL, RUN: advance = in_valid;
      DRAIN:     advance = 1'b1;
      default:   advance = 1'b0;
    endcase
  end

  // Next-state, sample counter and latched stop request.
  always_comb begin
    state_d    = state_q;
    stop_req_d = stop_req_q;
    cnt_d      = cnt_q;
    if (advance) begin
      cnt_d = cnt_at_last ? '0 : cnt_q + 1'b1;
    end
    case (state_q)
      IDLE: begin
        stop_req_d = 1'b0;
        if (start_conv) begin
          // A stop seen together with start is kept for this frame's end.
          stop_req_d = stop_conv;
          cnt_d      = in_valid ? AW'(1) : '0;
          state_d    = (in_valid && DEPTH == 1) ? RUN : FILL;
        end
      end
      FILL: begin
        stop_req_d = stop_req_q || stop_conv;
        if (in_valid && cnt_q == DEPTH_END) begin
          state_d = RUN;
        end
      end
      RUN: begin
        stop_req_d = stop_req_q || stop_conv;
        if (run_adv && cnt_at_last && (stop_req_q || stop_conv)) begin
          state_d    = DRAIN;
          stop_req_d = 1'b0;
        end
      end
      DRAIN: begin
        stop_req_d = 1'b0;
        if (drain_done) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d    = IDLE;
        cnt_d      = '0;
        stop_req_d = 1'b0;
      end
    endcase
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      stop_req_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      stop_req_q <= stop_req_d;
    end
  end

  // Stage p1: qualifiers aligned with the sel2-muxed serial output.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sel_p1  <= 1'b0;
      vld_p1  <= 1'b0;
      last_p1 <= 1'b0;
      end_p1  <= 1'b0;
    end else begin
      sel_p1  <= sel1;
      vld_p1  <= run_adv || (state_q == DRAIN);
      last_p1 <= run_adv && cnt_at_last;
      end_p1  <= drain_done;
    end
  end

  assign sel2      = sel_p1;
  assign out_valid = vld_p1;
  assign out_last  = last_p1;
  assign end_conv  = end_p1;

  sdf_twiddle_addr_gen #(
    .NFFT     (NFFT),
    .STAGE_NO (STAGE_NO),
    .AW       (AW)
  ) u_tw (
    .clk     (clk),
    .rst     (rst),
    .cnt     (cnt_q),
    .advance (advance),
    .drain   (state_q == DRAIN),
    .tw_addr (tw_addr),
    .tw_en   (tw_en)
  );

`ifdef SDF_SEQ_STATUS_EN
  // Frame counter and sticky protocol error flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      frame_cnt <= '0;
      err       <= 1'b0;
    end else begin
      if (last_p1) begin
        frame_cnt <= frame_cnt + 16'd1;
      end
      if ((start_conv && busy) || (in_valid && state_q == DRAIN)) begin
        err <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_sdf_stage_sequencer.sv
// Testbench for sdf_stage_sequencer: a 64-point stage-3 instance driven
// through a scoreboard of expected output beats and end_conv pulses, plus a
// 16-point stage-1 instance checked cycle by cycle.
`timescale 1ns/1ps
module tb_sdf_stage_sequencer;

  localparam int NFFT_A = 64;
  localparam int STG_A  = 3;
  localparam int AW_A   = 6;
  localparam int D_A    = 4;
  localparam int NFFT_B = 16;
  localparam int STG_B  = 1;
  localparam int AW_B   = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic start_a, stop_a, vin_a;
  logic sel1_a, sel2_a, tw_en_a, flush_a, out_valid_a, out_last_a, busy_a, end_conv_a;
  logic [AW_A-1:0] tw_addr_a;
  logic start_b, stop_b, vin_b;
  logic sel1_b, sel2_b, tw_en_b, flush_b, out_valid_b, out_last_b, busy_b, end_conv_b;
  logic [AW_B-1:0] tw_addr_b;
`ifdef SDF_SEQ_STATUS_EN
  logic [15:0] frame_cnt_a, frame_cnt_b;
  logic err_a, err_b;
`endif

  sdf_stage_sequencer #(.NFFT(NFFT_A), .STAGE_NO(STG_A), .AW(AW_A)) dut_a (
    .clk(clk), .rst(rst), .start_conv(start_a), .stop_conv(stop_a), .in_valid(vin_a),
    .sel1(sel1_a), .sel2(sel2_a), .tw_en(tw_en_a), .tw_addr(tw_addr_a), .flush(flush_a),
    .out_valid(out_valid_a), .out_last(out_last_a), .busy(busy_a), .end_conv(end_conv_a)
`ifdef SDF_SEQ_STATUS_EN
    , .frame_cnt(frame_cnt_a), .err(err_a)
`endif
  );

  sdf_stage_sequencer #(.NFFT(NFFT_B), .STAGE_NO(STG_B), .AW(AW_B)) dut_b (
    .clk(clk), .rst(rst), .start_conv(start_b), .stop_conv(stop_b), .in_valid(vin_b),
    .sel1(sel1_b), .sel2(sel2_b), .tw_en(tw_en_b), .tw_addr(tw_addr_b), .flush(flush_b),
    .out_valid(out_valid_b), .out_last(out_last_b), .busy(busy_b), .end_conv(end_conv_b)
`ifdef SDF_SEQ_STATUS_EN
    , .frame_cnt(frame_cnt_b), .err(err_b)
`endif
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct packed {
    int   at;
    logic last;
  } beat_t;

  beat_t exp_beats[$];
  int    exp_end[$];
  beat_t mon_b;
  int    mon_e;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic checkn(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops an expected beat whenever stage A presents out_valid.
  always @(negedge clk) begin
    if (rst) begin
      if (out_valid_a) begin
        if (exp_beats.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL beat_unexpected: out_valid=1 with no expected beat (cycle %0d)", cyc);
        end else begin
          mon_b = exp_beats.pop_front();
          checkn("beat_cycle", cyc, mon_b.at);
          check1("beat_last", out_last_a, mon_b.last);
        end
      end else if (out_last_a) begin
        checks++;
        failures++;
        $display("FAIL last_no_valid: out_last=1 out_valid=0 (cycle %0d)", cyc);
      end
      if (end_conv_a) begin
        if (exp_end.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL end_unexpected: end_conv=1 with none expected (cycle %0d)", cyc);
        end else begin
          mon_e = exp_end.pop_front();
          checkn("end_cycle", cyc, mon_e);
        end
      end
    end
  end

  // Stage A: one valid sample n (global index since start), entered at posedge+2.
  task automatic a_sample(input int n, input logic st, input logic sp);
    int    k;
    logic  exp_sel;
    beat_t b;
    k       = n % NFFT_A;
    exp_sel = k[2];
    vin_a = 1'b1; start_a = st; stop_a = sp;
    #1;
    check1("a_sel1", sel1_a, exp_sel);
    check1("a_tw_en", tw_en_a, !exp_sel);
    if (n >= D_A) begin
      b.at   = cyc + 1;
      b.last = (k == NFFT_A - 1);
      exp_beats.push_back(b);
    end
    @(posedge clk);
    #1;
    checkn("a_tw_addr", 32'(tw_addr_a), 32'((k % D_A) * (NFFT_A / (2 * D_A))));
    #1;
  endtask

  task automatic a_gap(input logic hold_sel, input int hold_addr);
    vin_a = 1'b0; start_a = 1'b0; stop_a = 1'b0;
    #1;
    check1("gap_sel1", sel1_a, hold_sel);
    check1("gap_tw_en", tw_en_a, 1'b0);
    @(posedge clk);
    #1;
    checkn("gap_tw_addr", 32'(tw_addr_a), 32'(hold_addr));
    #1;
  endtask

  task automatic a_drain();
    beat_t b;
    for (int i = 0; i < D_A; i++) begin
      vin_a = 1'b0; start_a = 1'b0; stop_a = 1'b0;
      #1;
      check1("drain_flush", flush_a, 1'b1);
      check1("drain_busy", busy_a, 1'b1);
      check1("drain_tw_en", tw_en_a, 1'b0);
      b.at   = cyc + 1;
      b.last = 1'b0;
      exp_beats.push_back(b);
      if (i == D_A - 1) exp_end.push_back(cyc + 1);
      @(posedge clk);
      #1;
      checkn("drain_tw_addr", 32'(tw_addr_a), 32'(i * (NFFT_A / (2 * D_A))));
      #1;
    end
    #1;
    check1("idle_busy", busy_a, 1'b0);
    check1("idle_flush", flush_a, 1'b0);
    @(posedge clk);
    #2;
  endtask

  task automatic a_frames(input int nsamp, input logic stop_with_start, input int stop_at,
                          input int gap_at, input int gap_len, input int restart_at);
    for (int n = 0; n < nsamp; n++) begin
      if (n == gap_at) begin
        for (int g = 0; g < gap_len; g++) begin
          a_gap(n[2], ((n - 1) % D_A) * (NFFT_A / (2 * D_A)));
        end
      end
      a_sample(n, (n == 0) || (n == restart_at), ((n == 0) && stop_with_start) || (n == stop_at));
    end
    a_drain();
  endtask

  task automatic b_run();
    for (int k = 0; k < NFFT_B; k++) begin
      vin_b = 1'b1; start_b = (k == 0); stop_b = (k == NFFT_B - 1);
      #1;
      check1("b_sel1", sel1_b, k[0]);
      check1("b_tw_en", tw_en_b, !k[0]);
      @(posedge clk);
      #1;
      checkn("b_tw_addr", 32'(tw_addr_b), 32'd0);
      check1("b_sel2", sel2_b, k[0]);
      check1("b_out_valid", out_valid_b, k >= 1);
      check1("b_out_last", out_last_b, k == NFFT_B - 1);
      #1;
    end
    vin_b = 1'b0; start_b = 1'b0; stop_b = 1'b0;
    #1;
    check1("b_drain_flush", flush_b, 1'b1);
    @(posedge clk);
    #1;
    check1("b_drain_valid", out_valid_b, 1'b1);
    check1("b_end_conv", end_conv_b, 1'b1);
    check1("b_busy_fall", busy_b, 1'b0);
    @(posedge clk);
    #1;
    check1("b_end_pulse", end_conv_b, 1'b0);
    check1("b_valid_off", out_valid_b, 1'b0);
    #1;
  endtask

  task automatic a_check_zero(input string tag);
    check1({tag, "_sel1"}, sel1_a, 1'b0);
    check1({tag, "_sel2"}, sel2_a, 1'b0);
    check1({tag, "_tw_en"}, tw_en_a, 1'b0);
    checkn({tag, "_tw_addr"}, 32'(tw_addr_a), 32'd0);
    check1({tag, "_flush"}, flush_a, 1'b0);
    check1({tag, "_out_valid"}, out_valid_a, 1'b0);
    check1({tag, "_out_last"}, out_last_a, 1'b0);
    check1({tag, "_busy"}, busy_a, 1'b0);
    check1({tag, "_end_conv"}, end_conv_a, 1'b0);
`ifdef SDF_SEQ_STATUS_EN
    checkn({tag, "_frame_cnt"}, 32'(frame_cnt_a), 32'd0);
    check1({tag, "_err"}, err_a, 1'b0);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b0;
    start_a = 1'b0; stop_a = 1'b0; vin_a = 1'b0;
    start_b = 1'b0; stop_b = 1'b0; vin_b = 1'b0;
    #2;
    a_check_zero("reset");
    check1("reset_b_busy", busy_b, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #2;

    // Single frame, contiguous input, stop requested near the frame end.
    a_frames(64, 1'b0, 60, -1, 0, -1);

    // Stop together with start, 3-cycle input gap at sample 10.
    a_frames(64, 1'b1, -1, 10, 3, -1);

    // Asynchronous reset while sample 30 is on the input.
    for (int n = 0; n < 30; n++) a_sample(n, n == 0, 1'b0);
    @(negedge clk);
    #1;
    vin_a = 1'b1;
    rst   = 1'b0;
    #1;
    a_check_zero("midrst");
    checkn("midrst_pending", exp_beats.size(), 0);
    vin_a = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #2;

    // Three back-to-back frames, start ignored mid-RUN, stop in the last frame.
    a_frames(192, 1'b0, 150, -1, 0, 70);
`ifdef SDF_SEQ_STATUS_EN
    checkn("status_frame_cnt", 32'(frame_cnt_a), 32'd3);
    check1("status_err", err_a, 1'b1);
`endif

    // Stage 1: depth-1 buffer, fixed twiddle address.
    b_run();

    repeat (2) @(posedge clk);
    #2;
    checkn("beats_left", exp_beats.size(), 0);
    checkn("ends_left", exp_end.size(), 0);
`ifdef SDF_SEQ_STATUS_EN
    check1("status_err_sticky", err_a, 1'b1);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sdf_stage_sequencer.md
Name: sdf_stage_sequencer

Overview:
- Control unit for one radix-2 single-delay-feedback (SDF) IFFT stage.
- Counts valid input samples per NFFT frame and generates the butterfly/MUX select, twiddle address and twiddle enable.
- Generates output-valid/last qualifiers aligned to the stage's serial output, and a flush phase that drains the feedback buffer after the final frame.
- Replaces the per-stage start-delay plus MUX/TF/address control-unit cluster with one sequencer instantiated once per stage.

Parameters:
- NFFT, 64, transform length; power of two, 4..1024.
- STAGE_NO, 1, stage index; feedback buffer depth D = 2**(STAGE_NO-1); 1 <= STAGE_NO <= log2(NFFT).
- AW, $clog2(NFFT), width of sample counter and twiddle address.

Ports:
- clk  in  1  stage clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- start_conv  in  1  one-cycle pulse; begins frame 0 (sampled in IDLE only).
- stop_conv  in  1  level; request to finish after the current frame.
- in_valid  in  1  serial input sample present this cycle.
- sel1  out  1  raw select = cnt[STAGE_NO-1]; high in the second half of each 2D block.
- sel2  out  1  sel1 registered one cycle; drives MUX1, MUX2 and butterfly enable.
- tw_en  out  1  twiddle multiply active.
- tw_addr  out  AW  twiddle ROM address.
- flush  out  1  datapath must accept zero input and advance the buffer.
- out_valid  out  1  stage serial output valid, aligned with sel2-muxed data.
- out_last  out  1  last output sample of a frame.
- busy  out  1  state != IDLE.
- end_conv  out  1  one-cycle pulse when the drain completes.

Behaviour:
- Reset (rst=0, async): state=IDLE, cnt=0; every output 0, tw_addr=0.
- Advance = (in_valid && state in {FILL,RUN}) || state==DRAIN. cnt increments mod NFFT on advance only; gaps in in_valid freeze cnt, sel1 and tw_addr.
- sel1 = cnt[STAGE_NO-1] combinationally while busy, else 0. sel2 = registered sel1.
- tw_addr = (cnt mod D) * (NFFT/(2D)), registered on advance; tw_en = advance && sel1==0 && state!=DRAIN.
- State transitions:
  - IDLE: start_conv=1 -> FILL, cnt=0. The same-cycle in_valid counts as sample 0.
  - FILL: after D advances -> RUN. out_valid held 0 in FILL.
  - RUN: out_valid = advance delayed 1 cycle. out_last = 1 on the output cycle of the sample at cnt=NFFT-1 (delayed 1 cycle).
  - RUN frame wrap: if stop_conv=1 is sampled on the advance with cnt=NFFT-1 -> DRAIN; otherwise stay in RUN and continue back-to-back frames.
- DRAIN:
  - flush=1; D cycles advance unconditionally; in_valid ignored.
  - out_valid=1 each drain cycle (delayed 1). Last drain cycle -> IDLE; end_conv pulses on the cycle IDLE is entered.
- Latency: first out_valid appears D+1 advances after sample 0.
- Boundary cases:
  - start_conv while busy: ignored.
  - stop_conv and start_conv in the same IDLE cycle: start wins; stop is honoured at that frame's end.
  - STAGE_NO=1 (D=1): tw_addr fixed 0; FILL lasts 1 advance.
  - Reset asserted mid-frame or mid-drain: immediate return to IDLE; no end_conv pulse.

Optional Feature:
- SDF_SEQ_STATUS_EN defined: adds two outputs.
  - frame_cnt[15:0]: increments on each out_last; wraps at 0xFFFF.
  - err (sticky): set when start_conv arrives while busy, or in_valid=1 arrives in DRAIN; cleared only by reset.
- Undefined: neither port exists; both conditions are silently ignored.

Decomposition:
- Shared package sdf_ctrl_pkg holds:
  - state encoding localparams: IDLE=2'd0, FILL=2'd1, RUN=2'd2, DRAIN=2'd3;
  - a log2 constant function;
  - depth macro D(STAGE_NO) reused by the datapath's Memory_Shifter instantiation.
- One natural sub-module: sdf_twiddle_addr_gen (cnt, advance -> tw_addr, tw_en), reused by every stage sequencer.

Test Plan:
- NFFT=64, STAGE_NO=3 (D=4), start_conv then 64 contiguous in_valid:
  - tw_addr sequence 0,8,16,24 repeating;
  - sel1 pattern 0000 1111 repeating;
  - first out_valid 5 cycles after sample 0; out_last one cycle after sample 63.
- Same setup with in_valid deasserted 3 cycles at sample 10: cnt, tw_addr and sel1 hold; out_valid=0 for those 3 cycles; total out_valid count unchanged.
- Two back-to-back frames, stop_conv raised during frame 1:
  - no FILL between frames; out_last twice;
  - DRAIN asserts flush for exactly 4 cycles; end_conv pulses once; busy falls.
- STAGE_NO=1: tw_addr always 0; sel1 toggles every sample; sel2 lags sel1 by 1 cycle.
- rst driven low at sample 30: all outputs 0 asynchronously; state returns to IDLE; no end_conv; a fresh start_conv restarts at cnt=0.
- SDF_SEQ_STATUS_EN defined:
  - start_conv issued mid-RUN sets err=1, which stays set;
  - three complete frames give frame_cnt=3.
